// File: rtl/noc_pkg.sv
// Shared constants and types for the router core's egress merge.
// Pure declarations: no logic, no latency, no flow control of its own.
// Imported by the merge_arbiter FSM and its round-robin arbiter.
package noc_pkg;

    localparam int ADDR_W    = 4;
    localparam int NUM_PORTS = 16;
    localparam int DATA_W    = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_RTZ
    } state_t;

    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first active request at or after ptr, mod NUM_PORTS.
// Purely combinational, zero latency.
// No backpressure: the caller decides when to consume the grant.
module rr_arbiter
    import noc_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  addr_t                ptr,
    output logic                 grant_valid,
    output addr_t                grant_idx
);

    // Scan from the farthest offset down so the nearest request to ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = ptr;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (req[ptr + addr_t'(k)]) begin
                grant_valid = 1'b1;
                grant_idx   = ptr + addr_t'(k);
            end
        end
    end

endmodule

// File: rtl/merge_arbiter.sv
// 16-to-1 4-phase merge: grants one input round-robin, forwards data plus source index.
// Latency: request sampled at edge N gives in_ack/out_req after edge N; all outputs registered.
// Backpressure: out_ack held low stalls in WAIT_ACK; other requests stay pending.
module merge_arbiter
    import noc_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_PORTS-1:0]              in_req,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]  in_data,
    output logic [NUM_PORTS-1:0]              in_ack,
    output logic                              out_req,
    output logic [DATA_W-1:0]                 out_data,
    output addr_t                             out_src,
    input  logic                              out_ack,
    output logic                              proto_err
);

    state_t state;
    state_t state_nxt;
    addr_t  rr_ptr;
    logic   in_busy;
    logic   grant_valid;
    addr_t  grant_idx;
    logic   grant;
    logic   in_rtz;

    rr_arbiter u_rr_arbiter (
        .req         (in_req),
        .ptr         (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // out_src doubles as the granted index g for the input-side handshake.
    always_comb begin
        state_nxt = state;
        grant     = (state == IDLE) && grant_valid;
        in_rtz    = (state != IDLE) && in_busy && !in_req[out_src];
        case (state)
            IDLE:     if (grant_valid)           state_nxt = WAIT_ACK;
            WAIT_ACK: if (out_ack)               state_nxt = WAIT_RTZ;
            WAIT_RTZ: if (!out_ack && !in_busy)  state_nxt = IDLE;
            default:                             state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            in_busy   <= 1'b0;
            in_ack    <= '0;
            out_req   <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            proto_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                out_data          <= in_data[grant_idx];
                out_src           <= grant_idx;
                out_req           <= 1'b1;
                in_ack[grant_idx] <= 1'b1;
                rr_ptr            <= grant_idx + addr_t'(1);
                in_busy           <= 1'b1;
            end
            if (in_rtz) begin
                in_ack[out_src] <= 1'b0;
                in_busy         <= 1'b0;
            end
            if ((state == WAIT_ACK) && out_ack) begin
                out_req <= 1'b0;
            end
            // An input dropping on the same edge the output acks is a clean finish.
            if (((state == IDLE) && out_ack) ||
                ((state == WAIT_ACK) && in_rtz && !out_ack)) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_merge_arbiter.sv
// Directed bench for merge_arbiter: vector table of single transfers plus corner sequences.
module tb_merge_arbiter;
    import noc_pkg::*;

    logic                             clk;
    logic                             rst_n;
    logic [NUM_PORTS-1:0]             in_req;
    logic [NUM_PORTS-1:0][DATA_W-1:0] in_data;
    logic [NUM_PORTS-1:0]             in_ack;
    logic                             out_req;
    logic [DATA_W-1:0]                out_data;
    addr_t                            out_src;
    logic                             out_ack;
    logic                             proto_err;

    int total = 0;
    int bad   = 0;

    merge_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_req    (in_req),
        .in_data   (in_data),
        .in_ack    (in_ack),
        .out_req   (out_req),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ack   (out_ack),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish act=timeout exp=finish");
        $fatal(1);
    end

    typedef struct packed {
        logic [15:0] req;
        logic [7:0]  seed;
        logic [3:0]  src;
        logic [7:0]  data;
        logic [3:0]  ptr;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] onehot(input int i);
        return 16'(1) << i;
    endfunction

    // Drops all requests and acks the output, then lets the FSM return to IDLE.
    task automatic finish_xfer();
        in_req  = '0;
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        step();
    endtask

    initial begin
        // req, seed (in_data[i] = seed + i), expected src, expected data, rr_ptr after
        vecs[0] = '{16'h0020, 8'h9E, 4'd5,  8'hA3, 4'd6};
        vecs[1] = '{16'h0081, 8'h10, 4'd7,  8'h17, 4'd8};
        vecs[2] = '{16'h8081, 8'h20, 4'd15, 8'h2F, 4'd0};
        vecs[3] = '{16'h8081, 8'h40, 4'd0,  8'h40, 4'd1};
        vecs[4] = '{16'h8081, 8'h55, 4'd7,  8'h5C, 4'd8};
        vecs[5] = '{16'hFFFF, 8'h00, 4'd8,  8'h08, 4'd9};
        vecs[6] = '{16'h0100, 8'hF0, 4'd8,  8'hF8, 4'd9};
        vecs[7] = '{16'h0200, 8'h01, 4'd9,  8'h0A, 4'd10};

        rst_n   = 1'b0;
        in_req  = '0;
        in_data = '0;
        out_ack = 1'b0;
        step();
        step();
        chk("rst_in_ack",    32'(in_ack),    32'h0);
        chk("rst_out_req",   32'(out_req),   32'h0);
        chk("rst_out_data",  32'(out_data),  32'h0);
        chk("rst_out_src",   32'(out_src),   32'h0);
        chk("rst_proto_err", 32'(proto_err), 32'h0);
        chk("rst_rr_ptr",    32'(dut.rr_ptr), 32'h0);
        rst_n = 1'b1;
        step();
        chk("idle_no_req_ack", 32'(in_ack), 32'h0);

        // Table of single transfers with simultaneous input drop and output ack.
        for (int n = 0; n < 8; n++) begin
            in_req = vecs[n].req;
            for (int i = 0; i < NUM_PORTS; i++) in_data[i] = vecs[n].seed + 8'(i);
            step();
            chk($sformatf("v%0d_in_ack", n),   32'(in_ack),   32'(onehot(int'(vecs[n].src))));
            chk($sformatf("v%0d_out_req", n),  32'(out_req),  32'h1);
            chk($sformatf("v%0d_out_src", n),  32'(out_src),  32'(vecs[n].src));
            chk($sformatf("v%0d_out_data", n), 32'(out_data), 32'(vecs[n].data));
            in_req  = '0;
            out_ack = 1'b1;
            step();
            chk($sformatf("v%0d_ack_low", n),  32'(in_ack),   32'h0);
            chk($sformatf("v%0d_req_low", n),  32'(out_req),  32'h0);
            chk($sformatf("v%0d_data_hold", n), 32'(out_data), 32'(vecs[n].data));
            out_ack = 1'b0;
            step();
            chk($sformatf("v%0d_idle", n),     32'(dut.state), 32'(IDLE));
            chk($sformatf("v%0d_rr_ptr", n),   32'(dut.rr_ptr), 32'(vecs[n].ptr));
            chk($sformatf("v%0d_src_hold", n), 32'(out_src),  32'(vecs[n].src));
        end
        chk("table_proto_err", 32'(proto_err), 32'h0);

        // Fairness with all inputs requesting and a minimum-latency environment.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) in_data[i] = 8'h80 + 8'(i);
        in_req = 16'hFFFF;
        step();
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("fair%0d_src", k),  32'(out_src),  32'(k % 16));
            chk($sformatf("fair%0d_ack", k),  32'(in_ack),   32'(onehot(k % 16)));
            chk($sformatf("fair%0d_data", k), 32'(out_data), 32'(8'h80 + 8'(k % 16)));
            in_req[k % 16] = 1'b0;
            out_ack        = 1'b1;
            step();
            out_ack        = 1'b0;
            in_req[k % 16] = 1'b1;
            step();
            step();
        end
        finish_xfer();
        chk("fair_rr_ptr", 32'(dut.rr_ptr), 32'd1);

        // Stalled downstream: output held, no other input acked.
        in_req     = onehot(3);
        in_data[3] = 8'h33;
        step();
        in_req = 16'hFFFF;
        for (int c = 0; c < 20; c++) begin
            step();
            chk($sformatf("stall%0d", c), {out_req, 7'h0, out_data, in_ack},
                {1'b1, 7'h0, 8'h33, 16'h0008});
        end
        finish_xfer();
        chk("stall_done_req", 32'(out_req), 32'h0);
        chk("stall_rr_ptr",   32'(dut.rr_ptr), 32'd4);

        // Reset in WAIT_ACK, then the held request is granted again.
        in_req      = onehot(12);
        in_data[12] = 8'hC5;
        step();
        chk("mid_grant", 32'(in_ack), 32'h1000);
        rst_n = 1'b0;
        step();
        chk("mid_rst_in_ack",   32'(in_ack),      32'h0);
        chk("mid_rst_out_req",  32'(out_req),     32'h0);
        chk("mid_rst_out_data", 32'(out_data),    32'h0);
        chk("mid_rst_rr_ptr",   32'(dut.rr_ptr),  32'h0);
        chk("mid_rst_state",    32'(dut.state),   32'(IDLE));
        rst_n = 1'b1;
        step();
        chk("mid_regrant_ack",  32'(in_ack),   32'h1000);
        chk("mid_regrant_src",  32'(out_src),  32'd12);
        chk("mid_regrant_data", 32'(out_data), 32'hC5);
        finish_xfer();

        // out_ack high in IDLE is sticky through a later clean transfer.
        out_ack = 1'b1;
        step();
        chk("err_idle_set", 32'(proto_err), 32'h1);
        out_ack   = 1'b0;
        in_req    = onehot(2);
        in_data[2] = 8'h2C;
        step();
        chk("err_idle_xfer_src", 32'(out_src), 32'd2);
        finish_xfer();
        chk("err_idle_sticky", 32'(proto_err), 32'h1);

        // Early input drop in WAIT_ACK flags an error but the transfer completes.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("err_rst_clear", 32'(proto_err), 32'h0);
        in_req     = onehot(6);
        in_data[6] = 8'h66;
        step();
        in_req = '0;
        step();
        chk("early_in_ack",    32'(in_ack),    32'h0);
        chk("early_out_req",   32'(out_req),   32'h1);
        chk("early_proto_err", 32'(proto_err), 32'h1);
        chk("early_state",     32'(dut.state), 32'(WAIT_ACK));
        out_ack = 1'b1;
        step();
        chk("early_ack_req", 32'(out_req),   32'h0);
        chk("early_rtz",     32'(dut.state), 32'(WAIT_RTZ));
        out_ack = 1'b0;
        step();
        chk("early_idle", 32'(dut.state), 32'(IDLE));
        chk("early_data", 32'(out_data),  32'h66);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
